// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter for a single-port line SRAM (async read, sync write).
// Bounded-burst tenures; read responses return registered one cycle after acceptance.
module sram_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned AW        = 5,
    parameter int unsigned DW        = 72
) (
    input  logic          clka,
    input  logic          rst,

    input  logic          m0_valid,
    output logic          m0_ready,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_valid,
    output logic          m1_ready,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          sram_ena,
    output logic          sram_wea,
    output logic [AW-1:0] sram_addra,
    output logic [DW-1:0] sram_dina,
    input  logic [DW-1:0] sram_douta
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] MAXB = 4'(MAX_BURST);

    state_t     state, state_nxt;
    logic [3:0] burst_cnt, burst_nxt;
    logic       last, last_nxt;
    logic       gnt0, gnt1;
    logic       cont;

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
            last      <= 1'b1;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            last      <= last_nxt;
        end
    end

    // cont marks a beat that extends the current tenure; any other grant starts a new one.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        cont = 1'b0;
        case (state)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    if (last) gnt0 = 1'b1;
                    else      gnt1 = 1'b1;
                end else if (m0_valid) begin
                    gnt0 = 1'b1;
                end else if (m1_valid) begin
                    gnt1 = 1'b1;
                end
            end
            OWN0: begin
                if (m0_valid && (burst_cnt < MAXB)) begin
                    gnt0 = 1'b1;
                    cont = 1'b1;
                end else if (m1_valid) begin
                    gnt1 = 1'b1;
                end else if (m0_valid) begin
                    gnt0 = 1'b1;
                end
            end
            OWN1: begin
                if (m1_valid && (burst_cnt < MAXB)) begin
                    gnt1 = 1'b1;
                    cont = 1'b1;
                end else if (m0_valid) begin
                    gnt0 = 1'b1;
                end else if (m1_valid) begin
                    gnt1 = 1'b1;
                end
            end
            default: begin
                gnt0 = 1'b0;
                gnt1 = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nxt = IDLE;
        burst_nxt = '0;
        last_nxt  = last;
        if (gnt0) begin
            state_nxt = OWN0;
            last_nxt  = 1'b0;
            burst_nxt = cont ? burst_cnt + 4'd1 : 4'd1;
        end else if (gnt1) begin
            state_nxt = OWN1;
            last_nxt  = 1'b1;
            burst_nxt = cont ? burst_cnt + 4'd1 : 4'd1;
        end
    end

    assign m0_ready = gnt0;
    assign m1_ready = gnt1;

    always_comb begin
        sram_ena   = 1'b0;
        sram_wea   = 1'b0;
        sram_addra = '0;
        sram_dina  = '0;
        if (gnt0) begin
            sram_ena   = 1'b1;
            sram_wea   = m0_we;
            sram_addra = m0_addr;
            sram_dina  = m0_wdata;
        end else if (gnt1) begin
            sram_ena   = 1'b1;
            sram_wea   = m1_we;
            sram_addra = m1_addr;
            sram_dina  = m1_wdata;
        end
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= gnt0 && !m0_we;
            m1_rvalid <= gnt1 && !m1_we;
            if (gnt0 && !m0_we) m0_rdata <= sram_douta;
            if (gnt1 && !m1_we) m1_rdata <= sram_douta;
        end
    end

endmodule
